// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Two independent requesters share one ALU through round-robin arbitration.
// An accepted operation is captured in a one-entry operand register (exec),
// evaluated by the ALU during the following cycle, and written into that
// requester's result holding register. The result stays there until the
// requester pops it. Each port may have at most one operation in flight, so
// the aggregate peak is one ALU op per cycle with the two ports alternating.
//
// Ports
//   clk          rising-edge clock for all state
//   reset        synchronous, active-high; clears all state
//   req0_valid   port 0 presents an operation
//   req0_ready   port 0 operation accepted this cycle (combinational grant)
//   req0_A/B     port 0 operands (32 bit)
//   req0_op      port 0 opcode (3 bit)
//   rsp0_valid   port 0 result is held
//   rsp0_data    port 0 result (32 bit)
//   rsp0_ready   port 0 consumes its held result
//   req1_*/rsp1_*  identical set for port 1
//   busy         the operand register holds an in-flight operation
//
// Opcodes: 000 add, 001 sub, 010 and, 011 or, 100 srl, 101 sra,
//          110/111 result 0.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// alu
//
// Purely combinational 32-bit ALU.
//   a, b  operands
//   op    opcode (encoding above)
//   c     result
// Shifts look at the full 32-bit shift amount: any amount of 32 or more
// shifts every bit out (zero for srl, sign fill for sra).
// -----------------------------------------------------------------------------
module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] c
);

    logic        shift_all_out;
    logic [31:0] sra_result;

    // Any set bit above bit 4 means the shift amount is at least 32.
    assign shift_all_out = |b[31:5];
    assign sra_result    = $signed(a) >>> b[4:0];

    always_comb begin
        c = 32'd0;
        case (op)
            3'b000:  c = a + b;
            3'b001:  c = a - b;
            3'b010:  c = a & b;
            3'b011:  c = a | b;
            3'b100:  c = shift_all_out ? 32'd0 : (a >> b[4:0]);
            3'b101:  c = shift_all_out ? {32{a[31]}} : sra_result;
            default: c = 32'd0;
        endcase
    end

endmodule

module alu_arbiter (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_A,
    input  logic [31:0] req0_B,
    input  logic [2:0]  req0_op,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_data,
    input  logic        rsp0_ready,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_A,
    input  logic [31:0] req1_B,
    input  logic [2:0]  req1_op,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_data,
    input  logic        rsp1_ready,

    output logic        busy
);

    // Operand register holding the operation the ALU evaluates this cycle.
    logic        exec_valid;
    logic        exec_id;
    logic [31:0] exec_A;
    logic [31:0] exec_B;
    logic [2:0]  exec_op;

    // Id of the most recent grant; the other port wins the next tie.
    logic        last;

    logic [31:0] alu_c;

    logic        outstanding0;
    logic        outstanding1;
    logic        eligible0;
    logic        eligible1;
    logic        grant_valid;
    logic        grant_id;

    logic        write_rsp0;
    logic        write_rsp1;

    alu u_alu (
        .a  (exec_A),
        .b  (exec_B),
        .op (exec_op),
        .c  (alu_c)
    );

    // A port is outstanding while its op sits in exec or its result is held.
    // A result being popped this cycle no longer counts, so the port can be
    // granted again in the same cycle it consumes its previous result.
    assign outstanding0 = (exec_valid && (exec_id == 1'b0)) || (rsp0_valid && !rsp0_ready);
    assign outstanding1 = (exec_valid && (exec_id == 1'b1)) || (rsp1_valid && !rsp1_ready);

    assign eligible0 = req0_valid && !outstanding0;
    assign eligible1 = req1_valid && !outstanding1;

    // Round-robin grant. Reset masks the grant so that nothing is reported
    // as accepted on an edge that is about to clear the operand register.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (!reset) begin
            if (eligible0 && eligible1) begin
                grant_valid = 1'b1;
                grant_id    = ~last;
            end else if (eligible0) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (eligible1) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    assign req0_ready = grant_valid && (grant_id == 1'b0);
    assign req1_ready = grant_valid && (grant_id == 1'b1);

    // Operand capture. Operands are only loaded on a grant; otherwise they
    // keep their old value and exec_valid drops, idling the ALU.
    always_ff @(posedge clk) begin
        if (reset) begin
            exec_valid <= 1'b0;
            exec_id    <= 1'b0;
            exec_A     <= 32'd0;
            exec_B     <= 32'd0;
            exec_op    <= 3'd0;
            last       <= 1'b1;
        end else if (grant_valid) begin
            exec_valid <= 1'b1;
            exec_id    <= grant_id;
            exec_op    <= grant_id ? req1_op : req0_op;
            exec_A     <= grant_id ? req1_A  : req0_A;
            exec_B     <= grant_id ? req1_B  : req0_B;
            last       <= grant_id;
        end else begin
            exec_valid <= 1'b0;
        end
    end

    assign write_rsp0 = exec_valid && (exec_id == 1'b0);
    assign write_rsp1 = exec_valid && (exec_id == 1'b1);

    // Port 0 result holder. A new result takes priority over a pop; the
    // one-outstanding rule keeps both from happening on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp0_valid <= 1'b0;
            rsp0_data  <= 32'd0;
        end else if (write_rsp0) begin
            rsp0_valid <= 1'b1;
            rsp0_data  <= alu_c;
        end else if (rsp0_valid && rsp0_ready) begin
            rsp0_valid <= 1'b0;
        end
    end

    // Port 1 result holder, same behaviour as port 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp1_valid <= 1'b0;
            rsp1_data  <= 32'd0;
        end else if (write_rsp1) begin
            rsp1_valid <= 1'b1;
            rsp1_data  <= alu_c;
        end else if (rsp1_valid && rsp1_ready) begin
            rsp1_valid <= 1'b0;
        end
    end

    assign busy = exec_valid;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Self-checking bench for alu_arbiter. Inputs change 1 time unit after each
// rising edge and outputs are sampled on the falling edge. A monitor keeps a
// transaction-level model of both ports (at most one pending result per
// port, due two edges after its accept) and checks grants, result timing,
// result data and the handshake rules every cycle. Directed sequences and a
// vector table add explicit expected values on top.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic [31:0] req0_A, req0_B, rsp0_data;
    logic [2:0]  req0_op;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [31:0] req1_A, req1_B, rsp1_data;
    logic [2:0]  req1_op;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;

    alu_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_A     (req0_A),
        .req0_B     (req0_B),
        .req0_op    (req0_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .rsp0_ready (rsp0_ready),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_A     (req1_A),
        .req1_B     (req1_B),
        .req1_op    (req1_op),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .rsp1_ready (rsp1_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Reference ALU written from the opcode table with plain arithmetic.
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        logic [31:0] ones;
        ones = 32'hFFFF_FFFF;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return (b >= 32'd32) ? 32'd0 : (a >> b);
            3'd5: begin
                if (b >= 32'd32) return a[31] ? ones : 32'd0;
                return (a >> b) | (a[31] ? ~(ones >> b) : 32'd0);
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h",
                     name, cycle, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input logic v, input logic [31:0] a,
                                 input logic [31:0] b, input logic [2:0] op, input logic rr);
        if (port == 0) begin
            req0_valid = v; req0_A = a; req0_B = b; req0_op = op; rsp0_ready = rr;
        end else begin
            req1_valid = v; req1_A = a; req1_B = b; req1_op = op; rsp1_ready = rr;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic resetDut();
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    // Transaction-level monitor / reference model
    // ---------------------------------------------------------------------
    bit          m_pend [2];
    logic [31:0] m_data [2];
    int          m_due  [2];
    int          m_last = 1;
    bit          acc_prev [2];

    always @(negedge clk) begin : monitor
        bit          vld [2];
        bit          rdy [2];
        bit          rv  [2];
        bit          rr  [2];
        logic [31:0] rd  [2];
        logic [31:0] aa  [2];
        logic [31:0] bb  [2];
        logic [2:0]  oo  [2];
        bit          vis [2];
        bit          pop [2];
        bit          outst [2];
        bit          elig [2];
        bit          g_any;
        int          g_id;

        vld[0] = req0_valid; rdy[0] = req0_ready; rv[0] = rsp0_valid; rr[0] = rsp0_ready;
        rd[0]  = rsp0_data;  aa[0]  = req0_A;     bb[0] = req0_B;     oo[0] = req0_op;
        vld[1] = req1_valid; rdy[1] = req1_ready; rv[1] = rsp1_valid; rr[1] = rsp1_ready;
        rd[1]  = rsp1_data;  aa[1]  = req1_A;     bb[1] = req1_B;     oo[1] = req1_op;

        if (reset) begin
            checkOutput("ready0_during_reset", {31'd0, rdy[0]}, 32'd0);
            checkOutput("ready1_during_reset", {31'd0, rdy[1]}, 32'd0);
            for (int n = 0; n < 2; n++) begin
                m_pend[n]   = 1'b0;
                acc_prev[n] = 1'b0;
            end
            m_last = 1;
        end else begin
            for (int n = 0; n < 2; n++) begin
                checkOutput($sformatf("ready_without_valid%0d", n),
                            {31'd0, rdy[n] && !vld[n]}, 32'd0);
                vis[n] = m_pend[n] && (cycle >= m_due[n]);
                checkOutput($sformatf("rsp%0d_valid", n), {31'd0, rv[n]}, {31'd0, vis[n]});
                if (vis[n])
                    checkOutput($sformatf("rsp%0d_data", n), rd[n], m_data[n]);
                pop[n]   = vis[n] && rr[n];
                outst[n] = m_pend[n] && !pop[n];
                elig[n]  = vld[n] && !outst[n];
                checkOutput($sformatf("write_during_pop%0d", n),
                            {31'd0, rv[n] && rr[n] && acc_prev[n]}, 32'd0);
                checkOutput($sformatf("one_outstanding%0d", n),
                            {31'd0, vld[n] && rdy[n] && outst[n]}, 32'd0);
            end

            g_any = elig[0] || elig[1];
            if (elig[0] && elig[1]) g_id = 1 - m_last;
            else if (elig[0])       g_id = 0;
            else                    g_id = 1;

            for (int n = 0; n < 2; n++)
                checkOutput($sformatf("req%0d_ready", n), {31'd0, rdy[n]},
                            {31'd0, g_any && (g_id == n)});

            for (int n = 0; n < 2; n++) begin
                if (pop[n]) m_pend[n] = 1'b0;
                acc_prev[n] = vld[n] && rdy[n];
            end
            if (g_any) begin
                m_pend[g_id] = 1'b1;
                m_data[g_id] = ref_alu(aa[g_id], bb[g_id], oo[g_id]);
                m_due[g_id]  = cycle + 2;
                m_last       = g_id;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Directed single operation on port 0 with explicit expected values
    // ---------------------------------------------------------------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] expected;
    } vec_t;

    task automatic runOp(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [31:0] expected);
        applyStimulus(0, 1'b1, a, b, op, 1'b1);
        @(negedge clk);
        checkOutput({name, "_accept"}, {31'd0, req0_ready}, 32'd1);
        tick();
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
        @(negedge clk);
        checkOutput({name, "_busy"}, {31'd0, busy}, 32'd1);
        tick();
        @(negedge clk);
        checkOutput({name, "_valid"}, {31'd0, rsp0_valid}, 32'd1);
        checkOutput({name, "_data"}, rsp0_data, expected);
        tick();
    endtask

    function automatic logic [31:0] rand_b();
        if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 40));
        return $urandom;
    endfunction

    vec_t vectors [15];

    initial begin
        reset = 1'b1;
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b1);

        vectors[0]  = '{32'd5,         32'd3,         3'd1, 32'd2};
        vectors[1]  = '{32'hFFFFFFFF,  32'd1,         3'd0, 32'd0};
        vectors[2]  = '{32'd0,         32'd1,         3'd1, 32'hFFFFFFFF};
        vectors[3]  = '{32'hF0F0F0F0,  32'hFF00FF00,  3'd2, 32'hF000F000};
        vectors[4]  = '{32'h0F0F0000,  32'h000000F0,  3'd3, 32'h0F0F00F0};
        vectors[5]  = '{32'h80000000,  32'd4,         3'd4, 32'h08000000};
        vectors[6]  = '{32'h80000000,  32'd32,        3'd4, 32'd0};
        vectors[7]  = '{32'h80000000,  32'd31,        3'd4, 32'd1};
        vectors[8]  = '{32'h80000000,  32'd4,         3'd5, 32'hF8000000};
        vectors[9]  = '{32'h80000000,  32'd40,        3'd5, 32'hFFFFFFFF};
        vectors[10] = '{32'h7FFFFFFF,  32'd40,        3'd5, 32'd0};
        vectors[11] = '{32'h80000000,  32'd31,        3'd5, 32'hFFFFFFFF};
        vectors[12] = '{32'h12345678,  32'h9ABCDEF0,  3'd6, 32'd0};
        vectors[13] = '{32'h12345678,  32'h9ABCDEF0,  3'd7, 32'd0};
        vectors[14] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  3'd4, 32'd0};

        tick();
        tick();
        @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        checkOutput("reset_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        tick();
        reset = 1'b0;

        // Single op, then the opcode / shift vector table, all on port 0.
        $display("[TB] single op and vector table");
        for (int i = 0; i < 15; i++)
            runOp($sformatf("vec%0d", i), vectors[i].a, vectors[i].b, vectors[i].op,
                  vectors[i].expected);
        idle(2);

        // Tie and round-robin: grants alternate starting with port 0.
        $display("[TB] tie and round-robin");
        resetDut();
        applyStimulus(0, 1'b1, 32'd1, 32'd1, 3'd0, 1'b1);
        applyStimulus(1, 1'b1, 32'h000000F0, 32'h0000000F, 3'd3, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput($sformatf("rr_grant0_%0d", i), {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput($sformatf("rr_grant1_%0d", i), {31'd0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i >= 2 && i % 2 == 0) checkOutput("rr_rsp0_data", rsp0_data, 32'd2);
            if (i >= 3 && i % 2 == 1) checkOutput("rr_rsp1_data", rsp1_data, 32'hFF);
            tick();
        end
        idle(3);

        // Backpressure: port 1 holds a result, port 0 gets every grant.
        $display("[TB] backpressure");
        resetDut();
        applyStimulus(1, 1'b1, 32'h000000FF, 32'h0000000F, 3'd2, 1'b0);
        @(negedge clk);
        checkOutput("bp_first_accept", {31'd0, req1_ready}, 32'd1);
        tick();
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
        tick();
        tick();
        applyStimulus(0, 1'b1, 32'd10, 32'd20, 3'd0, 1'b1);
        applyStimulus(1, 1'b1, 32'd1, 32'd2, 3'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_req1_ready_%0d", i), {31'd0, req1_ready}, 32'd0);
            checkOutput($sformatf("bp_rsp1_data_%0d", i), rsp1_data, 32'h0F);
            checkOutput($sformatf("bp_req0_ready_%0d", i), {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            tick();
        end
        rsp1_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_grant1", {31'd0, req1_ready}, 32'd1);
        tick();
        idle(4);

        // Reset while an op is in flight on port 1.
        $display("[TB] reset mid-operation");
        resetDut();
        applyStimulus(1, 1'b1, 32'd7, 32'd8, 3'd0, 1'b1);
        @(negedge clk);
        checkOutput("mid_accept1", {31'd0, req1_ready}, 32'd1);
        tick();
        reset = 1'b1;
        applyStimulus(0, 1'b1, 32'd3, 32'd4, 3'd0, 1'b1);
        applyStimulus(1, 1'b1, 32'd9, 32'd9, 3'd0, 1'b1);
        @(negedge clk);
        checkOutput("mid_ready0_in_reset", {31'd0, req0_ready}, 32'd0);
        checkOutput("mid_ready1_in_reset", {31'd0, req1_ready}, 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("mid_busy_after", {31'd0, busy}, 32'd0);
        checkOutput("mid_rsp1_after", {31'd0, rsp1_valid}, 32'd0);
        checkOutput("mid_tie_grant0", {31'd0, req0_ready}, 32'd1);
        checkOutput("mid_tie_grant1", {31'd0, req1_ready}, 32'd0);
        tick();
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("mid_no_stale_rsp1", {31'd0, rsp1_valid}, 32'd0);
            tick();
        end
        idle(2);

        // Randomized traffic on both ports, checked by the monitor.
        $display("[TB] randomized traffic");
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(0, $urandom_range(0, 9) < 7, $urandom, rand_b(),
                          3'($urandom_range(0, 7)), $urandom_range(0, 9) < 7);
            applyStimulus(1, $urandom_range(0, 9) < 7, $urandom, rand_b(),
                          3'($urandom_range(0, 7)), $urandom_range(0, 9) < 7);
            tick();
        end
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
